// File: rtl/conv_pool_bin_pkg.sv
// Shared constants and FSM encoding for the binarize + 2x2 max-pool stage
// that sits between conv and the next layer's window block.
package conv_pool_bin_pkg;

    localparam int DW    = 5;
    localparam int MAX_W = 26;

    // Layer geometry: square frames, state=0 selects L0, state=1 selects L1.
    localparam int L0_W = 26;
    localparam int L1_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/conv_pool_bin_if.sv
// Stream bundle between conv (producer), this pooling stage and the next window block.
// Handshake: no ready in either direction; ivalid qualifies din/idone on each rising
// edge, and the consumer must accept dout on every cycle ovalid is high.
interface conv_pool_bin_if #(
    parameter int DW = 5
);
    import conv_pool_bin_pkg::*;

    logic                 state;
    logic signed [DW-1:0] din;
    logic                 ivalid;
    logic                 idone;
    logic signed [DW-1:0] thresh;
    logic                 dout;
    logic                 ovalid;
    logic                 odone;
    logic                 busy;
    logic                 err;
    fsm_state_t           dbg_state;

    modport slave (
        input  state, din, ivalid, idone, thresh,
        output dout, ovalid, odone, busy, err, dbg_state
    );

    modport master (
        output state, din, ivalid, idone, thresh,
        input  dout, ovalid, odone, busy, err, dbg_state
    );

endinterface

// File: rtl/conv_pool_bin_pool_linebuf.sv
// One bit per pooling window column: holds the OR of the even-row pair
// until the odd row of the same window reads it back.
module pool_linebuf #(
    parameter int DEPTH = 13,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);

    logic [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we && (int'(waddr) < DEPTH)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_comb begin
        rdata = 1'b0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/conv_pool_bin.sv
// Binarizes signed conv results against thresh and ORs each 2x2 stride-2 window,
// emitting one pooled bit per completed window one cycle after its last pixel.
module conv_pool_bin
    import conv_pool_bin_pkg::*;
#(
    parameter int DW    = conv_pool_bin_pkg::DW,
    parameter int MAX_W = conv_pool_bin_pkg::MAX_W
) (
    input logic            clk,
    input logic            rstn,
    conv_pool_bin_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_W);
    localparam int LB_N  = MAX_W / 2;
    localparam int LB_AW = $clog2(LB_N);

    localparam logic [CNT_W-1:0] W_L0 = CNT_W'(L0_W);
    localparam logic [CNT_W-1:0] W_L1 = CNT_W'(L1_W);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    fsm_state_t       fsm_q, fsm_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             pend_q, pend_d;
    logic             pair_q, pair_d;
    logic             dout_q, dout_d;
    logic             ovalid_q, ovalid_d;
    logic             odone_q, odone_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic signed [DW-1:0] din_s;
    logic signed [DW-1:0] thr_s;
    logic                 start;
    logic [CNT_W-1:0]     w_eff;
    logic [CNT_W-1:0]     col_eff;
    logic [CNT_W-1:0]     row_eff;
    logic                 last_col;
    logic                 last_row;
    logic                 b;
    logic                 lb_we;
    logic                 lb_wdata;
    logic                 lb_rdata;
    logic [LB_AW-1:0]     lb_addr;

    assign din_s = bus.din;
    assign thr_s = bus.thresh;

    // A sample is pixel (0,0) either from IDLE or right after a frame that ran
    // past its last position without idone; geometry is re-latched in both cases.
    always_comb begin
        start    = (fsm_q == ST_IDLE) || pend_q;
        w_eff    = start ? (bus.state ? W_L1 : W_L0) : w_q;
        col_eff  = start ? '0 : col_q;
        row_eff  = start ? '0 : row_q;
        last_col = (col_eff == (w_eff - ONE));
        last_row = (row_eff == (w_eff - ONE));
        b        = (din_s >= thr_s);
    end

    assign lb_addr = LB_AW'(col_eff >> 1);

    always_comb begin
        fsm_d    = fsm_q;
        w_d      = w_q;
        col_d    = col_q;
        row_d    = row_q;
        pend_d   = pend_q;
        pair_d   = pair_q;
        dout_d   = dout_q;
        ovalid_d = 1'b0;
        odone_d  = 1'b0;
        busy_d   = busy_q;
        err_d    = err_q;
        lb_we    = 1'b0;
        lb_wdata = pair_q | b;

        if (bus.ivalid) begin
            case ({row_eff[0], col_eff[0]})
                2'b00:   pair_d = b;
                2'b01:   lb_we  = 1'b1;
                2'b10:   pair_d = b | lb_rdata;
                default: begin
                    dout_d   = pair_q | b;
                    ovalid_d = 1'b1;
                end
            endcase

            if (start) begin
                w_d = w_eff;
            end
            if (pend_q) begin
                err_d = 1'b1;
            end

            if (last_col && last_row) begin
                col_d  = '0;
                row_d  = '0;
                busy_d = 1'b1;
                if (bus.idone) begin
                    fsm_d   = ST_IDLE;
                    pend_d  = 1'b0;
                    odone_d = 1'b1;
                end else begin
                    fsm_d  = ST_RUN;
                    pend_d = 1'b1;
                end
            end else if (bus.idone) begin
                fsm_d  = ST_IDLE;
                col_d  = '0;
                row_d  = '0;
                pend_d = 1'b0;
                busy_d = 1'b0;
                err_d  = 1'b1;
            end else begin
                fsm_d  = ST_RUN;
                pend_d = 1'b0;
                busy_d = 1'b1;
                if (last_col) begin
                    col_d = '0;
                    row_d = row_eff + ONE;
                end else begin
                    col_d = col_eff + ONE;
                    row_d = row_eff;
                end
            end
        end else if (fsm_q == ST_IDLE) begin
            // busy is held through the odone cycle and drops here unless a new frame starts.
            busy_d = 1'b0;
        end
    end

    pool_linebuf #(
        .DEPTH(LB_N),
        .AW   (LB_AW)
    ) u_linebuf (
        .clk  (clk),
        .rst_n(rstn),
        .we   (lb_we),
        .waddr(lb_addr),
        .wdata(lb_wdata),
        .raddr(lb_addr),
        .rdata(lb_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q    <= ST_IDLE;
            w_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            pend_q   <= 1'b0;
            pair_q   <= 1'b0;
            dout_q   <= 1'b0;
            ovalid_q <= 1'b0;
            odone_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            w_q      <= w_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pend_q   <= pend_d;
            pair_q   <= pair_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
            odone_q  <= odone_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.ovalid    = ovalid_q;
    assign bus.odone     = odone_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = fsm_q;

endmodule

// File: doc/conv_pool_bin.md
Name: conv_pool_bin

Overview:
- Consumer end of the conv result stream: accepts signed 5-bit conv results (dout/ovalid/done of conv), binarizes each against a threshold and applies 2x2 stride-2 max-pooling (logical OR in the binary domain).
- Emits a 1-bit-per-cycle pooled stream that feeds the window block of the next layer.
- Sits between conv and the next window instance.

Parameters:
- DW, 5, width of signed conv result.
- MAX_W, 26, largest conv output row width; sizes the line buffer to MAX_W/2 bits.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- state  input  1  layer select: 0 = 26x26 in / 13x13 out, 1 = 8x8 in / 4x4 out; sampled at frame start.
- din  input  DW  signed conv result.
- ivalid  input  1  din valid (conv ovalid).
- idone  input  1  last result of frame (conv done); qualified by ivalid.
- thresh  input  DW  signed binarization threshold.
- dout  output  1  pooled binary value.
- ovalid  output  1  dout valid.
- odone  output  1  pulses with the last pooled value of a frame.
- busy  output  1  frame in progress.
- err  output  1  sticky framing error.

Behaviour:
- Reset (rstn=0, asynchronous): dout, ovalid, odone, busy and err = 0; counters, line buffer and FSM cleared.
- Binarize: b = (signed din >= signed thresh) ? 1 : 0. Full DW-bit signed compare, no saturation.
- Frame geometry latched at frame start: W = 26 (state=0) or 8 (state=1); H = W.
- A state change mid-frame is ignored until the next frame starts.
- FSM has two states:
  - IDLE: the first ivalid latches W, sets busy=1 and goes to RUN. That sample is processed as pixel (0,0).
  - RUN: each ivalid advances col 0..W-1, then row 0..H-1.
- Pooling:
  - Even row, even col: hold b in a pair register.
  - Even row, odd col: write (pair | b) into linebuf[col>>1].
  - Odd row, even col: pair = b | linebuf[col>>1].
  - Odd row, odd col: pooled = pair | b.
- Output timing:
  - pooled is registered to dout with ovalid=1 exactly one cycle after the accepting edge (latency 1).
  - ovalid is otherwise 0; dout holds its last value.
- Outputs per frame: (W/2)^2, i.e. 169 or 16, in raster order.
- ivalid=0 cycles stall all counters; no bubbles are required at the input.
- Normal end: ivalid & idone at row=H-1, col=W-1.
  - odone=1 in the same cycle as the final ovalid.
  - Next cycle: busy=0, FSM returns to IDLE, counters cleared.
- Early idone (ivalid & idone at any other position):
  - Frame aborted: counters and FSM cleared, busy=0, err=1 (sticky until reset).
  - The current sample's pooled output is still emitted if that position completes a window.
  - odone is not asserted.
- Overrun: ivalid after the last position without idone sets err=1. The block then treats that sample as the start of a new frame.
- Back-to-back frames: ivalid in the cycle after the odone edge starts a new frame with no dead cycle required.
- Line buffer is never cleared between frames. Each entry is written on the even row before it is read on the odd row.
- No backpressure: the downstream consumer must accept every ovalid.

Decomposition:
- Shared package holds:
  - DW, MAX_W.
  - Layer geometry constants: L0_W=26, L1_W=8.
  - FSM state encoding.
- Natural sub-module: pool_linebuf, a MAX_W/2 x 1-bit register array with one write port and one combinational read port indexed by col>>1.

Test Plan:
- state=0, 676 results all = 3, thresh=0, idone on the 676th -> 169 ovalid pulses all dout=1; odone coincides with the 169th; busy falls the cycle after.
- state=1, 8x8 with din=-1 everywhere except (3,5)=+2, thresh=0 -> 16 outputs; only output index 1*4+2=6 is 1.
- state=1, din equal to thresh at one pixel per window -> all 16 outputs 1, confirming the >= compare.
- state=1 with ivalid deasserted every other cycle -> identical 16-bit output sequence; each ovalid exactly 1 cycle after its odd-row/odd-col input.
- state=0, idone asserted at sample 300 -> err=1, odone never pulses, busy=0; a subsequent clean state=1 frame yields 16 correct outputs with err still 1.
- rstn pulsed low mid-frame (sample 40 of an 8x8 frame) -> all outputs 0 immediately; a following full frame produces the correct 16 outputs.
